// File: rtl/morse_encoder.sv
// morse_encoder: turns one accepted character code into a keyed Morse waveform
// with per-element dot/dash strobes and ITU unit timing.
module morse_encoder #(
    parameter int UNIT_CYCLES = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] char_code_i,
    input  logic       char_valid_i,
    output logic       ready_o,
    output logic       key_o,
    output logic       dot_o,
    output logic       dash_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] T4 = CW'(4 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, KEY_ON, GAP_SYM, GAP_CHAR, GAP_WORD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d, len_q, len_d;
    logic [4:0]      pat_q, pat_d;
    logic            dot_q, dot_d, dash_q, dash_d, err_q, err_d, key_q, ready_q;
    logic [7:0]      lut;
    logic            done, last, elem;

    // {length, pattern left-aligned, 1 = dash}
    always_comb begin
        lut = '0;
        case (char_code_i)
            6'd0:  lut = {3'd2, 5'b01000};
            6'd1:  lut = {3'd4, 5'b10000};
            6'd2:  lut = {3'd4, 5'b10100};
            6'd3:  lut = {3'd3, 5'b10000};
            6'd4:  lut = {3'd1, 5'b00000};
            6'd5:  lut = {3'd4, 5'b00100};
            6'd6:  lut = {3'd3, 5'b11000};
            6'd7:  lut = {3'd4, 5'b00000};
            6'd8:  lut = {3'd2, 5'b00000};
            6'd9:  lut = {3'd4, 5'b01110};
            6'd10: lut = {3'd3, 5'b10100};
            6'd11: lut = {3'd4, 5'b01000};
            6'd12: lut = {3'd2, 5'b11000};
            6'd13: lut = {3'd2, 5'b10000};
            6'd14: lut = {3'd3, 5'b11100};
            6'd15: lut = {3'd4, 5'b01100};
            6'd16: lut = {3'd4, 5'b11010};
            6'd17: lut = {3'd3, 5'b01000};
            6'd18: lut = {3'd3, 5'b00000};
            6'd19: lut = {3'd1, 5'b10000};
            6'd20: lut = {3'd3, 5'b00100};
            6'd21: lut = {3'd4, 5'b00010};
            6'd22: lut = {3'd3, 5'b01100};
            6'd23: lut = {3'd4, 5'b10010};
            6'd24: lut = {3'd4, 5'b10110};
            6'd25: lut = {3'd4, 5'b11000};
            6'd26: lut = {3'd5, 5'b11111};
            6'd27: lut = {3'd5, 5'b01111};
            6'd28: lut = {3'd5, 5'b00111};
            6'd29: lut = {3'd5, 5'b00011};
            6'd30: lut = {3'd5, 5'b00001};
            6'd31: lut = {3'd5, 5'b00000};
            6'd32: lut = {3'd5, 5'b10000};
            6'd33: lut = {3'd5, 5'b11000};
            6'd34: lut = {3'd5, 5'b11100};
            6'd35: lut = {3'd5, 5'b11110};
            default: lut = '0;
        endcase
    end

    assign done = cnt_q == '0;
    assign last = (idx_q + 3'd1) == len_q;
    assign elem = pat_q[3'd4 - idx_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = done ? cnt_q : cnt_q - CW'(1);
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (char_valid_i) begin
                if (char_code_i < 6'd36) begin
                    state_d = KEY_ON;
                    cnt_d   = lut[4] ? T3 : T1;
                    len_d   = lut[7:5];
                    pat_d   = lut[4:0];
                    idx_d   = '0;
                    dot_d   = ~lut[4];
                    dash_d  = lut[4];
                end else if (char_code_i == 6'd36) begin
                    state_d = GAP_WORD;
                    cnt_d   = T4;
                end else begin
                    err_d   = 1'b1;
                end
            end
            KEY_ON: if (done) begin
                state_d = last ? GAP_CHAR : GAP_SYM;
                cnt_d   = last ? T3 : T1;
                idx_d   = last ? idx_q : idx_q + 3'd1;
            end
            GAP_SYM: if (done) begin
                state_d = KEY_ON;
                cnt_d   = elem ? T3 : T1;
                dot_d   = ~elem;
                dash_d  = elem;
            end
            GAP_CHAR, GAP_WORD: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            key_q   <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            key_q   <= state_d == KEY_ON;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            err_q   <= err_d;
            ready_q <= state_d == IDLE;
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = ~ready_q;
    assign key_o   = key_q;
    assign dot_o   = dot_q;
    assign dash_o  = dash_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: cycle model built from Morse strings plus literal timing checks.
module tb_morse_encoder;
    localparam int U = 4;

    logic       clk = 1'b0, rst = 1'b1, cv = 1'b0, cv1 = 1'b0;
    logic [5:0] cc = '0, cc1 = '0;
    logic       ready, key, dot, dash, busy, err;
    logic       r1, k1, d1, h1, b1, e1;

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk_i(clk), .rst_i(rst), .char_code_i(cc), .char_valid_i(cv),
        .ready_o(ready), .key_o(key), .dot_o(dot), .dash_o(dash),
        .busy_o(busy), .err_o(err)
    );

    morse_encoder #(.UNIT_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .char_code_i(cc1), .char_valid_i(cv1),
        .ready_o(r1), .key_o(k1), .dot_o(d1), .dash_o(h1),
        .busy_o(b1), .err_o(e1)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                        "--...", "---..", "----."};

    typedef struct packed {logic key, dot, dash, ready, err;} exp_t;
    localparam exp_t IDLE_E = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    exp_t q[$];
    exp_t e_cur = IDLE_E;
    logic live = 1'b0;

    // Expected per-cycle outputs, one entry per clock edge from the accept edge on.
    function automatic void build(input int code);
        string m;
        if (code < 36) begin
            m = tbl[code];
            for (int i = 0; i < m.len(); i++) begin
                bit ds = m[i] == "-";
                int n = ds ? 3 * U : U;
                int g = (i == m.len() - 1) ? 3 * U : U;
                for (int j = 0; j < n; j++)
                    q.push_back('{1'b1, j == 0 && !ds, j == 0 && ds, 1'b0, 1'b0});
                for (int j = 0; j < g; j++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
            end
        end else if (code == 36) begin
            for (int j = 0; j < 4 * U; j++) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end else begin
            q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        end
    endfunction

    initial forever begin
        @(posedge clk);
        live = 1'b1;
        if (rst) begin
            q.delete();
            e_cur = IDLE_E;
        end else if (q.size() > 0) begin
            e_cur = q.pop_front();
        end else if (cv && e_cur.ready) begin
            build(int'(cc));
            e_cur = q.pop_front();
        end else begin
            e_cur = IDLE_E;
        end
    end

    initial forever begin
        @(negedge clk);
        if (live) begin
            n_chk++;
            if ({key, dot, dash, ready, err, busy} != {e_cur, ~e_cur.ready}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got key/dot/dash/ready/err/busy=%b%b%b%b%b%b want %b%b",
                         $time, key, dot, dash, ready, err, busy, e_cur, ~e_cur.ready);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic send(input int code, output int lat, output int kc, output int nd,
                        output int nh, output int ne, output string s);
        @(negedge clk);
        #1 cc = 6'(code);
        cv = 1'b1;
        @(posedge clk);
        #1 cv = 1'b0;
        lat = 0; kc = 0; nd = 0; nh = 0; ne = int'(err); s = "";
        while (!ready && lat < 500) begin
            kc += int'(key);
            if (dot) begin nd++; s = {s, "."}; end
            if (dash) begin nh++; s = {s, "-"}; end
            @(posedge clk);
            #1 lat++;
        end
        if (lat >= 500) chk("ready_timeout", lat, -1);
    endtask

    initial begin
        int lat, kc, nd, nh, ne, k;
        string s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_key", int'(key), 0);
        rst = 1'b0;

        send(4, lat, kc, nd, nh, ne, s);
        chk("E_ready_edge", lat, 16); chk("E_key_cycles", kc, 4); chk("E_dots", nd, 1); chk("E_dashes", nh, 0);
        send(0, lat, kc, nd, nh, ne, s);
        chk("A_ready_edge", lat, 32); chk("A_key_cycles", kc, 16); chk("A_dots", nd, 1); chk("A_dashes", nh, 1);
        send(26, lat, kc, nd, nh, ne, s);
        chk("0_ready_edge", lat, 88); chk("0_key_cycles", kc, 60); chk("0_dashes", nh, 5);
        send(36, lat, kc, nd, nh, ne, s);
        chk("space_ready_edge", lat, 16); chk("space_key_cycles", kc, 0); chk("space_strobes", nd + nh, 0);
        send(40, lat, kc, nd, nh, ne, s);
        chk("inv_err", ne, 1); chk("inv_ready_edge", lat, 0);
        send(4, lat, kc, nd, nh, ne, s);
        chk("after_inv_ready_edge", lat, 16); chk("after_inv_dots", nd, 1);

        @(negedge clk);
        #1 cc = 6'd19;
        cv = 1'b1;
        @(posedge clk);
        #1 chk("T_key_on", int'(key), 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("rst_mid_key", int'(key), 0);
        chk("rst_mid_ready", int'(ready), 1);
        chk("rst_mid_dash", int'(dash), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cv = 1'b0;
        send(19, lat, kc, nd, nh, ne, s);
        chk("T_ready_edge", lat, 24); chk("T_key_cycles", kc, 12); chk("T_dashes", nh, 1);

        for (int c = 0; c < 36; c++) begin
            send(c, lat, kc, nd, nh, ne, s);
            k = -1;
            for (int i = 0; i < 36; i++) if (tbl[i] == s) k = i;
            chk("decode", k, c);
        end

        @(negedge clk);
        #1 cc1 = 6'd4;
        cv1 = 1'b1;
        @(posedge clk);
        #1 cv1 = 1'b0;
        lat = 0; kc = 0; nd = int'(d1);
        while (!r1 && lat < 50) begin
            kc += int'(k1);
            @(posedge clk);
            #1 lat++;
        end
        chk("u1_key_cycles", kc, 1); chk("u1_ready_edge", lat, 4); chk("u1_dot", nd, 1);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
